// File: rtl/afe_spi_attenuator.sv
// ============================================================================
// afe_spi_attenuator: LSB-first serial writer for the two AFE step attenuators.
// Revision: 1.0
// ============================================================================
`default_nettype none

module afe_spi_attenuator #(
  parameter int CLK_RATE   = 99999001,
  parameter int SPI_RATE   = 1000000,
  parameter int WORD_WIDTH = 16
) (
  input  logic                  sysClk,
  input  logic                  sysReset,
  input  logic                  wrStrobe,
  input  logic [1:0]            wrChannel,
  input  logic [WORD_WIDTH-1:0] wrData,
  output logic                  busy,
  output logic                  overrun,
  output logic [WORD_WIDTH-1:0] readback0,
  output logic [WORD_WIDTH-1:0] readback1,
  output logic [1:0]            AFE_SPI_CLK,
  output logic [1:0]            AFE_SPI_SDI,
  output logic [1:0]            AFE_SPI_LE
);

  localparam int HALF  = (CLK_RATE + 2*SPI_RATE - 1) / (2*SPI_RATE);
  localparam int CNT_W = (HALF < 1) ? 1 : $clog2(HALF + 1);
  localparam int BIT_W = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;

  localparam logic [CNT_W-1:0] c_RELOAD   = CNT_W'(HALF - 1);
  localparam logic [BIT_W-1:0] c_LAST_BIT = BIT_W'(WORD_WIDTH - 1);

  generate
    if (HALF < 1) begin : g_half_check
      $error("afe_spi_attenuator: HALF must be at least 1");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SHIFT_LO = 3'd1,
    S_SHIFT_HI = 3'd2,
    S_LE_SETUP = 3'd3,
    S_LE_HIGH  = 3'd4
  } state_t;

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [BIT_W-1:0]      r_bit;
  logic [WORD_WIDTH-1:0] r_data;
  logic [1:0]            r_mask;
  logic                  r_busy;
  logic                  r_overrun;
  logic [WORD_WIDTH-1:0] r_rb0;
  logic [WORD_WIDTH-1:0] r_rb1;
  logic [1:0]            r_clk;
  logic [1:0]            r_sdi;
  logic [1:0]            r_le;

  logic                  w_accept;
  logic                  w_cnt_done;
  logic [BIT_W-1:0]      w_next_bit;

  assign w_accept   = wrStrobe && !r_busy && (wrChannel != 2'b00);
  assign w_cnt_done = (r_cnt == '0);
  assign w_next_bit = r_bit + BIT_W'(1);

  always_ff @(posedge sysClk) begin
    if (sysReset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit     <= '0;
      r_data    <= '0;
      r_mask    <= '0;
      r_busy    <= 1'b0;
      r_overrun <= 1'b0;
      r_rb0     <= '0;
      r_rb1     <= '0;
      r_clk     <= '0;
      r_sdi     <= '0;
      r_le      <= '0;
    end else begin
      // A strobe that lands while a word is still going out is dropped.
      if (wrStrobe && r_busy) begin
        r_overrun <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_data    <= wrData;
            r_mask    <= wrChannel;
            r_bit     <= '0;
            r_overrun <= 1'b0;
            r_busy    <= 1'b1;
            r_cnt     <= c_RELOAD;
            r_clk     <= 2'b00;
            r_sdi     <= wrChannel & {2{wrData[0]}};
            r_state   <= S_SHIFT_LO;
          end
        end

        S_SHIFT_LO: begin
          if (w_cnt_done) begin
            r_cnt   <= c_RELOAD;
            r_clk   <= r_mask;
            r_state <= S_SHIFT_HI;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end

        S_SHIFT_HI: begin
          if (w_cnt_done) begin
            r_cnt <= c_RELOAD;
            r_clk <= 2'b00;
            if (r_bit != c_LAST_BIT) begin
              r_bit   <= w_next_bit;
              r_sdi   <= r_mask & {2{r_data[w_next_bit]}};
              r_state <= S_SHIFT_LO;
            end else begin
              r_sdi   <= 2'b00;
              r_state <= S_LE_SETUP;
            end
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end

        S_LE_SETUP: begin
          if (w_cnt_done) begin
            r_cnt   <= c_RELOAD;
            r_le    <= r_mask;
            r_state <= S_LE_HIGH;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end

        S_LE_HIGH: begin
          if (w_cnt_done) begin
            r_le    <= 2'b00;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
            if (r_mask[0]) begin
              r_rb0 <= r_data;
            end
            if (r_mask[1]) begin
              r_rb1 <= r_data;
            end
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign overrun     = r_overrun;
  assign readback0   = r_rb0;
  assign readback1   = r_rb1;
  assign AFE_SPI_CLK = r_clk;
  assign AFE_SPI_SDI = r_sdi;
  assign AFE_SPI_LE  = r_le;

endmodule

`default_nettype wire

// File: tb/tb_afe_spi_attenuator.sv
// ============================================================================
// tb_afe_spi_attenuator: table-driven and randomized checks of the AFE SPI writer.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_afe_spi_attenuator;

  localparam int HALF = 4;
  localparam int W    = 16;
  localparam int TLEN = (2*W + 2) * HALF;

  logic        sysClk = 1'b0;
  logic        sysReset;
  logic        wrStrobe;
  logic [1:0]  wrChannel;
  logic [15:0] wrData;
  logic        busy;
  logic        overrun;
  logic [15:0] readback0;
  logic [15:0] readback1;
  logic [1:0]  AFE_SPI_CLK;
  logic [1:0]  AFE_SPI_SDI;
  logic [1:0]  AFE_SPI_LE;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_rb0 = '0;
  logic [15:0] m_rb1 = '0;
  logic        m_ovr = 1'b0;

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  mask;
    int          ovr_at;
    int          rst_at;
    logic [15:0] e_rb0;
    logic [15:0] e_rb1;
    logic        e_ovr;
  } vec_t;

  vec_t vecs[9];

  always #5 sysClk = ~sysClk;

  afe_spi_attenuator #(
    .CLK_RATE   (8),
    .SPI_RATE   (1),
    .WORD_WIDTH (16)
  ) dut (
    .sysClk      (sysClk),
    .sysReset    (sysReset),
    .wrStrobe    (wrStrobe),
    .wrChannel   (wrChannel),
    .wrData      (wrData),
    .busy        (busy),
    .overrun     (overrun),
    .readback0   (readback0),
    .readback1   (readback1),
    .AFE_SPI_CLK (AFE_SPI_CLK),
    .AFE_SPI_SDI (AFE_SPI_SDI),
    .AFE_SPI_LE  (AFE_SPI_LE)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [39:0] snap();
    return {busy, overrun, AFE_SPI_CLK, AFE_SPI_SDI, AFE_SPI_LE, readback0, readback1};
  endfunction

  // Expected outputs t cycles after the accepting edge, from the waveform rules.
  function automatic logic [39:0] model(input logic [15:0] d, input logic [1:0] m,
                                        input int t, input logic ovr);
    int p;
    logic [1:0] e_clk, e_sdi, e_le;
    p = (t - 1) / HALF;
    e_clk = 2'b00;
    e_sdi = 2'b00;
    e_le  = 2'b00;
    if (p < 2*W) begin
      e_clk = (p % 2 == 1) ? m : 2'b00;
      e_sdi = d[p/2] ? m : 2'b00;
    end else if (p == 2*W + 1) begin
      e_le = m;
    end
    return {1'b1, ovr, e_clk, e_sdi, e_le, m_rb0, m_rb1};
  endfunction

  // Called and returns at a falling edge; the next call may strobe in that same cycle.
  task automatic do_write(input logic [15:0] d, input logic [1:0] m,
                          input int ovr_at, input int rst_at, input string tag);
    int          bad;
    int          first_t;
    logic [39:0] first_act, first_exp, e, a;
    logic [15:0] cap[2];
    int          rises[2], last_rise[2], le_cnt[2];
    logic        spacing_ok[2];
    logic [1:0]  prev_clk;

    wrStrobe  = 1'b1;
    wrData    = d;
    wrChannel = m;
    @(negedge sysClk);
    wrStrobe = 1'b0;
    bad = 0;
    first_t = 0;
    first_act = '0;
    first_exp = '0;

    if (m == 2'b00) begin
      for (int t = 1; t <= 8; t++) begin
        a = snap();
        e = {1'b0, m_ovr, 6'b0, m_rb0, m_rb1};
        if (a !== e && bad++ == 0) begin
          first_t = t; first_act = a; first_exp = e;
        end
        @(negedge sysClk);
      end
      check($sformatf("%s_zero_mask bad_cycles(first t=%0d got %h exp %h)",
                      tag, first_t, first_act, first_exp), bad, 0);
      return;
    end

    prev_clk = 2'b00;
    for (int ch = 0; ch < 2; ch++) begin
      cap[ch] = '0; rises[ch] = 0; last_rise[ch] = 0; le_cnt[ch] = 0; spacing_ok[ch] = 1'b1;
    end

    for (int t = 1; t <= TLEN; t++) begin
      a = snap();
      if (rst_at != 0 && t > rst_at)
        e = '0;
      else
        e = model(d, m, t, (ovr_at != 0 && t > ovr_at));
      if (a !== e && bad++ == 0) begin
        first_t = t; first_act = a; first_exp = e;
      end
      for (int ch = 0; ch < 2; ch++) begin
        if (AFE_SPI_CLK[ch] && !prev_clk[ch]) begin
          cap[ch] = {AFE_SPI_SDI[ch], cap[ch][15:1]};
          if (rises[ch] != 0 && t - last_rise[ch] != 2*HALF) spacing_ok[ch] = 1'b0;
          rises[ch]++;
          last_rise[ch] = t;
        end
        if (AFE_SPI_LE[ch]) le_cnt[ch]++;
      end
      prev_clk = AFE_SPI_CLK;

      if (t == ovr_at) begin
        wrStrobe = 1'b1; wrData = 16'hFFFF; wrChannel = 2'b11;
      end else begin
        wrStrobe = 1'b0;
      end
      sysReset = (t == rst_at);
      @(negedge sysClk);
    end
    sysReset = 1'b0;

    if (rst_at != 0) begin
      m_rb0 = '0; m_rb1 = '0; m_ovr = 1'b0;
    end else begin
      if (m[0]) m_rb0 = d;
      if (m[1]) m_rb1 = d;
      m_ovr = (ovr_at != 0);
    end

    check($sformatf("%s_wave bad_cycles(first t=%0d got %h exp %h)",
                    tag, first_t, first_act, first_exp), bad, 0);
    check({tag, "_end_state"}, snap(), {1'b0, m_ovr, 6'b0, m_rb0, m_rb1});
    for (int ch = 0; ch < 2; ch++) begin
      if (rst_at != 0) begin
        check($sformatf("%s_le_cycles_ch%0d", tag, ch), le_cnt[ch], 0);
      end else begin
        check($sformatf("%s_le_cycles_ch%0d", tag, ch), le_cnt[ch], m[ch] ? HALF : 0);
        check($sformatf("%s_sclk_rises_ch%0d", tag, ch), rises[ch], m[ch] ? W : 0);
        if (m[ch]) begin
          check($sformatf("%s_shifted_word_ch%0d", tag, ch), cap[ch], d);
          check($sformatf("%s_sclk_spacing_ch%0d", tag, ch), spacing_ok[ch], 1'b1);
        end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sysReset  = 1'b1;
    wrStrobe  = 1'b0;
    wrData    = '0;
    wrChannel = 2'b00;
    repeat (3) @(negedge sysClk);
    check("reset_state", snap(), 40'h0);
    sysReset = 1'b0;
    @(negedge sysClk);
    check("idle_after_reset", snap(), 40'h0);

    //             data      mask  ovr rst  rb0       rb1       ovr
    vecs[0] = '{16'hA5C3, 2'b01, 0,  0,  16'hA5C3, 16'h0000, 1'b0};
    vecs[1] = '{16'h0001, 2'b11, 0,  0,  16'h0001, 16'h0001, 1'b0};
    vecs[2] = '{16'h5A5A, 2'b10, 50, 0,  16'h0001, 16'h5A5A, 1'b1};
    vecs[3] = '{16'h00FF, 2'b00, 0,  0,  16'h0001, 16'h5A5A, 1'b1};
    vecs[4] = '{16'h1234, 2'b01, 0,  0,  16'h1234, 16'h5A5A, 1'b0};
    vecs[5] = '{16'h0F0F, 2'b00, 0,  0,  16'h1234, 16'h5A5A, 1'b0};
    vecs[6] = '{16'hBEEF, 2'b11, 0,  70, 16'h0000, 16'h0000, 1'b0};
    vecs[7] = '{16'hC0DE, 2'b10, 0,  0,  16'h0000, 16'hC0DE, 1'b0};
    vecs[8] = '{16'h8001, 2'b01, 0,  0,  16'h8001, 16'hC0DE, 1'b0};

    for (int i = 0; i < 9; i++) begin
      do_write(vecs[i].data, vecs[i].mask, vecs[i].ovr_at, vecs[i].rst_at, $sformatf("vec%0d", i));
      check($sformatf("vec%0d_readback0", i), readback0, vecs[i].e_rb0);
      check($sformatf("vec%0d_readback1", i), readback1, vecs[i].e_rb1);
      check($sformatf("vec%0d_overrun", i), overrun, vecs[i].e_ovr);
    end

    for (int i = 0; i < 16; i++) begin
      logic [15:0] d;
      logic [1:0]  m;
      int          ov;
      d  = 16'($urandom);
      m  = 2'($urandom_range(1, 3));
      ov = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 130)) : 0;
      do_write(d, m, ov, 0, $sformatf("rnd%0d", i));
    end

    repeat (5) @(negedge sysClk);
    check("final_idle", snap(), {1'b0, m_ovr, 6'b0, m_rb0, m_rb1});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/afe_spi_attenuator.md
# afe_spi_attenuator

Serial driver for the two AFE front-end step attenuators on the DSBPM LBL208 carrier. It sits between the processor CSR write path in the common DSBPM top level and the AFE_SPI_CLK / AFE_SPI_SDI / AFE_SPI_LE pins. It accepts one 16-bit control word per write, shifts it LSB-first to one or both AFE boards, and pulses latch-enable. It keeps a per-channel shadow of the last word that was latched.

## Interface
- CLK_RATE, 99999001: sysClk frequency in Hz.
- SPI_RATE, 1000000: maximum SCLK frequency in Hz.
- WORD_WIDTH, 16: bits per transfer.
- HALF (localparam) = (CLK_RATE + 2*SPI_RATE - 1) / (2*SPI_RATE). This is 50 at the defaults. Elaboration fails if HALF < 1.

Ports:
- sysClk  in  1  system clock.
- sysReset  in  1  synchronous, active-high reset.
- wrStrobe  in  1  single-cycle write request.
- wrChannel  in  2  channel mask; bit n selects AFE n.
- wrData  in  WORD_WIDTH  word to shift.
- busy  out  1  transfer in progress.
- overrun  out  1  sticky flag: a write was dropped.
- readback0, readback1  out  WORD_WIDTH  last latched word per channel.
- AFE_SPI_CLK  out  2  serial clock per channel.
- AFE_SPI_SDI  out  2  serial data per channel.
- AFE_SPI_LE  out  2  latch enable per channel.

## Operation
- Reset values: busy=0, overrun=0, readback0=readback1=0, AFE_SPI_CLK=0, AFE_SPI_SDI=0, AFE_SPI_LE=0. The state machine returns to IDLE.
- Accepting a write:
  - A write is accepted when wrStrobe=1, busy=0 and wrChannel≠0.
  - On acceptance, wrData and wrChannel are registered, the bit index is cleared and overrun is cleared.
- Rejected writes:
  - wrStrobe with busy=1 is ignored and sets overrun=1. The flag stays set until the next accepted write or reset.
  - wrStrobe with wrChannel=0 is ignored. busy is not asserted and overrun is unchanged.
- State machine: IDLE → SHIFT_LO → SHIFT_HI → (repeat for each bit) → LE_SETUP → LE_HIGH → IDLE.
  - IDLE: all outputs low. An accepted write moves to SHIFT_LO.
  - SHIFT_LO (HALF cycles): CLK=0 on selected channels; SDI = data[bit].
  - SHIFT_HI (HALF cycles): CLK=1; SDI is held.
    - If bit < WORD_WIDTH-1: increment bit and go to SHIFT_LO.
    - Otherwise go to LE_SETUP.
  - LE_SETUP (HALF cycles): CLK=0, SDI=0, LE=0.
  - LE_HIGH (HALF cycles): LE=1 on selected channels. On exit, readback of each selected channel is loaded with the registered word, then the FSM returns to IDLE.
- Unselected channels keep CLK, SDI and LE at 0 for the whole transfer.
- Both channels selected: they are driven identically and in the same cycle.
- Bit order is LSB-first: data[0] is the first bit clocked.
- A single down-counter of ceil(log2(HALF+1)) bits times each state. It is reloaded to HALF-1 on every state entry.
- Reset during a transfer: the next edge forces IDLE and all reset values, including clearing both readbacks. No partial LE pulse is produced.

## Timing
- Write accepted at edge 0. busy=1 from cycle 1 through cycle (2*WORD_WIDTH+2)*HALF, and busy=0 on the following cycle. At the defaults this is 1700 cycles, which is 17 µs.
- SDI changes only on SHIFT_LO entry, which gives HALF cycles of setup and HALF cycles of hold around each rising SCLK.
- All pin outputs are driven directly from registers, with no combinational path to the pins.
- readback updates in the same cycle that LE falls and busy falls.
- A new strobe is accepted in the first cycle with busy=0, so back-to-back transfers have no extra gap.

## Test plan
- Bench parameters are CLK_RATE=8 and SPI_RATE=1, giving HALF=4 and a 136-cycle transfer.
- Single channel: write 0xA5C3 with mask 01.
  - Channel 0 shows 16 SCLK rising edges, 8 cycles apart. Sampled SDI reads 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1.
  - LE is high for 4 cycles.
  - readback0=0xA5C3, readback1=0. Channel 1 pins stay low throughout.
  - busy is high for exactly 136 cycles.
- Both channels: write 0x0001 with mask 11. Both channels' waveforms are identical and cycle-aligned, and both readbacks equal 0x0001.
- Overrun: pulse a second strobe with 0xFFFF at cycle 50 of a transfer.
  - The second write is ignored, overrun=1, and the first word completes intact.
  - The next accepted write clears overrun.
- Zero mask: strobe with mask 00. busy stays 0, all pins stay low, overrun stays 0.
- Reset mid-transfer: assert sysReset at cycle 70. On the next edge all outputs are 0 and the state is IDLE, no LE pulse ever occurs, and both readbacks are 0.
- Back-to-back: issue the second strobe in the first cycle where busy=0. It is accepted immediately and readback shows the second word after another 136 cycles.
